// File: rtl/watchdog_reset_multi.sv
// Multi-channel heartbeat watchdog that owns the core reset (boot hold, trip pulse, retry/fault latch).
// Latency: heartbeat edge acts on the counters 3 clk after the input edge; ext_reset_i reaches sys_reset_o combinationally.
// Backpressure: none; heartbeats are sampled every cycle and the reset output is never stalled.
module watchdog_reset_multi #(
  parameter int N_CH         = 2,
  parameter int CNT_W        = 27,
  parameter int TIMEOUT      = 13_500_000,
  parameter int BOOT_HOLD    = 1024,
  parameter int RESET_HOLD   = 270_000,
  parameter int MAX_RETRY    = 3,
  parameter int ARM_ON_FIRST = 1,
  parameter int EDGE_POL     = 1
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic [N_CH-1:0] ch_en_i,
  input  logic [N_CH-1:0] heartbeat_i,
  input  logic            ext_reset_i,
  input  logic            clear_fault_i,
  output logic            sys_reset_o,
  output logic [N_CH-1:0] timeout_ch_o,
  output logic [7:0]      retry_cnt_o,
  output logic            fault_o
);

  localparam int HOLD_MAX = (BOOT_HOLD > RESET_HOLD) ? BOOT_HOLD : RESET_HOLD;
  localparam int HOLD_W   = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  localparam logic [HOLD_W-1:0] BOOT_LAST  = HOLD_W'(BOOT_HOLD - 1);
  localparam logic [HOLD_W-1:0] RESET_LAST = HOLD_W'(RESET_HOLD - 1);
  localparam logic [CNT_W-1:0]  TO_VAL     = CNT_W'(TIMEOUT);
  localparam logic [7:0]        MAX_R      = 8'(MAX_RETRY);

  typedef enum logic [2:0] {S_BOOT, S_ARM, S_RUN, S_HOLD, S_FAULT} state_e;

  state_e                        state_q, state_d;
  logic [HOLD_W-1:0]             timer_q, timer_d;
  logic [N_CH-1:0]               seen_q, seen_d;
  logic [7:0]                    retry_q, retry_d, retry_inc;
  logic [N_CH-1:0]               tch_q, tch_d;
  logic [N_CH-1:0][CNT_W-1:0]    cnt_q, cnt_d;
  logic                          rst_lvl_q, rst_lvl_d;
  logic                          fault_q, fault_d;

  // Polarity is folded in before the synchroniser so the flops always reset to the inactive level.
  logic [N_CH-1:0] hb_pol, sync1_q, sync2_q, dly_q, edge_q;
  logic [N_CH-1:0] trip_mask;
  logic            trip, all_seen, go_fault;

  assign hb_pol = (EDGE_POL != 0) ? heartbeat_i : ~heartbeat_i;

  // Two-flop synchroniser, then a registered one-cycle edge pulse per channel.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
      dly_q   <= '0;
      edge_q  <= '0;
    end else begin
      sync1_q <= hb_pol;
      sync2_q <= sync1_q;
      dly_q   <= sync2_q;
      edge_q  <= sync2_q & ~dly_q;
    end
  end

  // Per-channel timeout counters and trip mask; an edge in the saturation cycle suppresses the trip.
  always_comb begin
    cnt_d     = '0;
    trip_mask = '0;
    for (int i = 0; i < N_CH; i++) begin
      if ((state_q == S_RUN) && !ext_reset_i && ch_en_i[i]) begin
        trip_mask[i] = (cnt_q[i] == TO_VAL) && !edge_q[i];
        if (edge_q[i])               cnt_d[i] = '0;
        else if (cnt_q[i] < TO_VAL)  cnt_d[i] = cnt_q[i] + CNT_W'(1);
        else                         cnt_d[i] = cnt_q[i];
      end
    end
    trip      = |trip_mask;
    all_seen  = (((seen_q | edge_q) & ch_en_i) == ch_en_i);
    retry_inc = (retry_q == 8'hFF) ? 8'hFF : retry_q + 8'd1;
    go_fault  = (MAX_RETRY != 0) && (retry_inc >= MAX_R);
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= S_BOOT;
    else          state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_BOOT: if (timer_q == BOOT_LAST) begin
        if (ARM_ON_FIRST != 0) state_d = S_ARM;
        else                   state_d = S_RUN;
      end
      S_ARM:  if (all_seen) state_d = S_RUN;
      S_RUN:  if (trip) begin
        if (go_fault) state_d = S_FAULT;
        else          state_d = S_HOLD;
      end
      S_HOLD: if (timer_q == RESET_LAST) begin
        if (ARM_ON_FIRST != 0) state_d = S_ARM;
        else                   state_d = S_RUN;
      end
      S_FAULT: if (clear_fault_i) state_d = S_BOOT;
      default: state_d = S_BOOT;
    endcase
  end

  // FSM outputs, computed from the next state so the registered reset level tracks the state.
  always_comb begin
    rst_lvl_d = (state_d == S_BOOT) || (state_d == S_HOLD) || (state_d == S_FAULT);
    fault_d   = (state_d == S_FAULT);
  end

  // Hold timer, first-edge tracking, retry count and sticky trip cause.
  always_comb begin
    timer_d = '0;
    seen_d  = '0;
    retry_d = retry_q;
    tch_d   = tch_q;
    if (state_d == state_q) begin
      if ((state_q == S_BOOT) || (state_q == S_HOLD)) timer_d = timer_q + HOLD_W'(1);
      if ((state_q == S_ARM)  || (state_q == S_RUN))  seen_d  = seen_q | edge_q;
    end
    if (state_q == S_RUN) begin
      if (trip) begin
        retry_d = retry_inc;
        tch_d   = trip_mask;
      end else if (all_seen) begin
        retry_d = '0;
      end
    end
    if ((state_q == S_FAULT) && clear_fault_i) begin
      retry_d = '0;
      tch_d   = '0;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      timer_q   <= '0;
      seen_q    <= '0;
      retry_q   <= '0;
      tch_q     <= '0;
      cnt_q     <= '0;
      rst_lvl_q <= 1'b1;
      fault_q   <= 1'b0;
    end else begin
      timer_q   <= timer_d;
      seen_q    <= seen_d;
      retry_q   <= retry_d;
      tch_q     <= tch_d;
      cnt_q     <= cnt_d;
      rst_lvl_q <= rst_lvl_d;
      fault_q   <= fault_d;
    end
  end

  assign sys_reset_o  = rst_lvl_q | ext_reset_i;
  assign timeout_ch_o = tch_q;
  assign retry_cnt_o  = retry_q;
  assign fault_o      = fault_q;

endmodule

// File: tb/tb_watchdog_reset_multi.sv
// Bench for watchdog_reset_multi: directed boot/trip/fault/race scenarios followed by random traffic.
// Latency: a cycle-level reference model queues the expected outputs; a monitor compares them every cycle.
// Backpressure: none; the bench drives inputs at posedge+2 and samples outputs on the falling edge.
module tb_watchdog_reset_multi;
  localparam int TO = 16, BH = 8, RH = 4, MR = 2;
  localparam int P_BOOT = 0, P_ARM = 1, P_RUN = 2, P_HOLD = 3, P_FAULT = 4;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic [1:0] ch_en = 2'b11, heartbeat = 2'b00;
  logic       ext_reset = 1'b0, clear_fault = 1'b0;
  logic       sys_reset, fault;
  logic [1:0] timeout_ch;
  logic [7:0] retry_cnt;

  int checks = 0, failures = 0, cyc = 0;

  always #5 clk = ~clk;

  watchdog_reset_multi #(
    .N_CH(2), .CNT_W(8), .TIMEOUT(TO), .BOOT_HOLD(BH), .RESET_HOLD(RH),
    .MAX_RETRY(MR), .ARM_ON_FIRST(1), .EDGE_POL(1)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .ch_en_i(ch_en), .heartbeat_i(heartbeat),
    .ext_reset_i(ext_reset), .clear_fault_i(clear_fault),
    .sys_reset_o(sys_reset), .timeout_ch_o(timeout_ch), .retry_cnt_o(retry_cnt), .fault_o(fault)
  );

  // Reference model: phase, countdown, heartbeat age per channel, first-edge flags.
  int         m_phase, m_left, m_retry;
  int         m_age [2];
  bit         m_seen [2];
  bit   [1:0] m_tch;
  bit   [3:0] m_hist [2];
  logic [11:0] exp_q [$];

  function automatic void m_enter(input int p);
    m_phase = p;
    m_seen  = '{0, 0};
    m_left  = (p == P_BOOT) ? BH : (p == P_HOLD) ? RH : 0;
  endfunction

  function automatic void m_reset();
    m_enter(P_BOOT);
    m_retry = 0;
    m_tch   = 2'b00;
    m_age   = '{0, 0};
    m_hist  = '{4'b0, 4'b0};
  endfunction

  function automatic void m_step();
    bit e [2];
    bit tm [2];
    bit any_trip, all_seen;
    any_trip = 0;
    all_seen = 1;
    for (int i = 0; i < 2; i++) begin
      e[i]  = m_hist[i][2] & ~m_hist[i][3];
      tm[i] = ch_en[i] && (m_phase == P_RUN) && !ext_reset && (m_age[i] == TO) && !e[i];
      any_trip = any_trip | tm[i];
      if (ch_en[i] && !(m_seen[i] || e[i])) all_seen = 0;
    end
    for (int i = 0; i < 2; i++) begin
      if ((m_phase == P_RUN) && ch_en[i] && !ext_reset)
        m_age[i] = e[i] ? 0 : ((m_age[i] < TO) ? m_age[i] + 1 : TO);
      else
        m_age[i] = 0;
    end
    case (m_phase)
      P_BOOT: begin m_left--; if (m_left == 0) m_enter(P_ARM); end
      P_ARM: begin
        for (int i = 0; i < 2; i++) m_seen[i] = m_seen[i] | e[i];
        if (all_seen) m_enter(P_RUN);
      end
      P_RUN: begin
        if (any_trip) begin
          m_tch   = {tm[1], tm[0]};
          m_retry = (m_retry < 255) ? m_retry + 1 : 255;
          if (m_retry >= MR) m_enter(P_FAULT);
          else               m_enter(P_HOLD);
        end else begin
          for (int i = 0; i < 2; i++) m_seen[i] = m_seen[i] | e[i];
          if (all_seen) m_retry = 0;
        end
      end
      P_HOLD: begin m_left--; if (m_left == 0) m_enter(P_ARM); end
      default: if (clear_fault) begin m_retry = 0; m_tch = 2'b00; m_enter(P_BOOT); end
    endcase
    for (int i = 0; i < 2; i++) m_hist[i] = {m_hist[i][2:0], heartbeat[i]};
  endfunction

  // Model process: advance on each rising edge, then queue the outputs expected for this cycle.
  initial begin
    logic es;
    m_reset();
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst_n) m_reset();
      else        m_step();
      #3;
      if (!rst_n) m_reset();
      es = (m_phase == P_BOOT) || (m_phase == P_HOLD) || (m_phase == P_FAULT) || ext_reset;
      exp_q.push_back({es, m_tch, 8'(m_retry), (m_phase == P_FAULT)});
    end
  end

  // Monitor: pop one expected record per cycle and compare against the DUT outputs.
  initial begin
    logic [11:0] ex, ac;
    @(posedge clk);
    forever begin
      @(negedge clk);
      ac = {sys_reset, timeout_ch, retry_cnt, fault};
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL scoreboard_empty cyc=%0d got outputs=%h expected a queued record", cyc, ac);
      end else begin
        ex = exp_q.pop_front();
        if (ac !== ex) begin
          failures++;
          $display("FAIL scoreboard cyc=%0d got sys_reset=%b timeout_ch=%b retry_cnt=%0d fault=%b expected sys_reset=%b timeout_ch=%b retry_cnt=%0d fault=%b",
                   cyc, ac[11], ac[10:9], ac[8:1], ac[0], ex[11], ex[10:9], ex[8:1], ex[0]);
        end
      end
    end
  end

  // Heartbeat generator state.
  bit alive [2];
  int per [2], ph [2], fc [2];

  task automatic step();
    @(posedge clk);
    #2;
    for (int i = 0; i < 2; i++) begin
      if (fc[i] > 0) begin heartbeat[i] = 1'b1; fc[i]--; end
      else             heartbeat[i] = alive[i] && (ph[i] < 2);
      ph[i] = (ph[i] + 1 >= per[i]) ? 0 : ph[i] + 1;
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  task automatic count_rst(input int n, output int hi);
    hi = 0;
    repeat (n) begin
      @(negedge clk);
      if (sys_reset) hi++;
      step();
    end
  endtask

  initial begin
    int n, k;
    alive = '{0, 0}; per = '{10, 10}; ph = '{0, 5}; fc = '{0, 0};
    repeat (3) step();

    // Boot hold, then ARM waits for first edges with no counting.
    rst_n = 1'b1;
    count_rst(50, n);  chk("boot_hold_len", n, BH);
    alive = '{1, 1};
    count_rst(40, n);  chk("arm_to_run_quiet", n, 0);

    // Healthy run.
    count_rst(200, n); chk("healthy_no_reset", n, 0);
    chk("healthy_retry", retry_cnt, 0);

    // Single trip on ch1, then recovery keeps the sticky cause.
    alive[1] = 0;
    count_rst(40, n);  chk("trip_pulse_len", n, RH);
    chk("trip_cause", timeout_ch, 2);
    chk("trip_retry", retry_cnt, 1);
    alive[1] = 1;
    count_rst(60, n);  chk("recover_no_reset", n, 0);
    chk("recover_retry", retry_cnt, 0);
    chk("recover_cause_sticky", timeout_ch, 2);

    // Two consecutive trips on ch0 reach FAULT.
    alive[0] = 0;
    count_rst(40, n);  chk("trip1_pulse_len", n, RH);
    chk("trip1_retry", retry_cnt, 1);
    fc[0] = 2;
    count_rst(50, n);
    chk("fault_flag", fault, 1);
    chk("fault_retry", retry_cnt, 2);
    chk("fault_cause", timeout_ch, 1);
    count_rst(1000, n); chk("fault_hold", n, 1000);
    alive = '{1, 1};
    clear_fault = 1'b1;
    step();
    clear_fault = 1'b0;
    chk("clear_retry", retry_cnt, 0);
    chk("clear_cause", timeout_ch, 0);
    chk("clear_fault_flag", fault, 0);
    count_rst(50, n);  chk("reboot_hold_len", n, BH);

    // Edge arriving exactly when the counter saturates never trips.
    per[0] = 17;
    count_rst(30, n);
    count_rst(200, n); chk("edge_at_saturation", n, 0);
    chk("edge_at_saturation_retry", retry_cnt, 0);
    per[0] = 10;
    count_rst(20, n);

    // ext_reset is passed straight through and does not disturb the FSM.
    ext_reset = 1'b1;
    count_rst(3, n);
    ext_reset = 1'b0;
    chk("ext_reset_len", n, 3);
    count_rst(40, n);  chk("after_ext_quiet", n, 0);

    // Disabled dead channel never trips; re-enabled channel starts from zero.
    ch_en = 2'b01; alive[1] = 0;
    count_rst(100, n); chk("disabled_dead_ch", n, 0);
    ch_en = 2'b11; alive[1] = 1;
    count_rst(40, n);  chk("reenabled_quiet", n, 0);

    // Asynchronous reset in the middle of HOLD.
    alive[0] = 0;
    k = 0;
    while (k < 60) begin
      @(negedge clk);
      if (sys_reset) break;
      step();
      k++;
    end
    chk("hold_reached", int'(k < 60), 1);
    chk("hold_retry", retry_cnt, 1);
    step();
    rst_n = 1'b0;
    #1;
    chk("async_sys_reset", sys_reset, 1);
    chk("async_fault", fault, 0);
    chk("async_retry", retry_cnt, 0);
    chk("async_cause", timeout_ch, 0);
    step(); step();
    rst_n = 1'b1;
    alive = '{1, 1};

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      step();
      ext_reset   = ($urandom_range(0, 39) == 0);
      clear_fault = ($urandom_range(0, 29) == 0);
      rst_n       = ($urandom_range(0, 799) != 0);
      if ($urandom_range(0, 149) == 0) ch_en = 2'($urandom_range(0, 3));
      for (int i = 0; i < 2; i++) begin
        if ($urandom_range(0, 99) == 0)  alive[i] = ~alive[i];
        if ($urandom_range(0, 199) == 0) per[i] = $urandom_range(6, 22);
      end
    end
    step();
    ext_reset = 1'b0; clear_fault = 1'b0; rst_n = 1'b1;
    repeat (3) step();
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/watchdog_reset_multi.md
Name: watchdog_reset_multi

Overview:
Multi-channel, parametrised system watchdog that generates the core reset. It is the successor to the single-vsync 500 ms watchdog. Each channel monitors one heartbeat (vsync, CPU tick, audio frame strobe, ...) with a per-channel enable. A missed heartbeat produces a bounded reset pulse rather than a level held until recovery. After MAX_RETRY consecutive failed recoveries the block latches a permanent fault. Sits between the board reset/PLL-lock logic and the core top; sys_reset fans out to every core domain on clk.

Parameters:
N_CH, 2, number of heartbeat channels (1..8)
CNT_W, 27, per-channel counter width
TIMEOUT, 13_500_000, cycles without a heartbeat edge before trip (500 ms at 27 MHz); must satisfy 2 <= TIMEOUT < 2^CNT_W
BOOT_HOLD, 1024, cycles sys_reset stays asserted after rst_n release
RESET_HOLD, 270_000, cycles of the sys_reset pulse after a trip (10 ms)
MAX_RETRY, 3, consecutive trips before FAULT; 0 disables fault latching
ARM_ON_FIRST, 1, 1 = counters frozen until each enabled channel shows its first edge
EDGE_POL, 1, 1 = rising-edge heartbeat, 0 = falling-edge

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
ch_en  in  N_CH  per-channel enable (synchronous, quasi-static)
heartbeat  in  N_CH  asynchronous heartbeat inputs
ext_reset  in  1  external reset request, active-high
clear_fault  in  1  single-cycle pulse; exits FAULT
sys_reset  out  1  core reset, active-high
timeout_ch  out  N_CH  sticky cause: channels that caused the last trip
retry_cnt  out  8  consecutive trips since last healthy run
fault  out  1  high in FAULT state

Behaviour:
- rst_n low (async):
  - FSM=BOOT; counters, hold timer, retry_cnt, timeout_ch, fault = 0; sys_reset = 1.
  - Synchroniser flops are cleared to the inactive level.
- Heartbeat path:
  - 2-flop synchroniser per channel, then an edge-detect flop.
  - An input edge produces a one-cycle edge pulse 3 clk later.
- Channel counter, active only in RUN with ch_en[i]=1 and ext_reset=0:
  - Edge clears the counter to 0.
  - Otherwise it increments while < TIMEOUT and saturates at TIMEOUT.
  - Edge and saturation in the same cycle: edge wins, no trip.
  - Outside RUN, when disabled, or while ext_reset=1: counter held at 0.
- trip = OR over enabled channels of (counter == TIMEOUT), evaluated in RUN only.
- FSM:
  - BOOT: hold timer counts BOOT_HOLD cycles, then go to ARM if ARM_ON_FIRST else RUN.
  - ARM: sys_reset = 0. Counters frozen. Go to RUN once every enabled channel has produced >= 1 edge since entering ARM (or immediately if no channel is enabled).
  - RUN: sys_reset = 0.
    - On trip: timeout_ch <= tripping mask; retry_cnt += 1 (saturating at 255).
    - If MAX_RETRY != 0 and the new retry_cnt >= MAX_RETRY, go to FAULT; else go to HOLD.
  - HOLD: sys_reset = 1 for exactly RESET_HOLD cycles, then go to ARM if ARM_ON_FIRST else RUN.
  - FAULT: sys_reset = 1, fault = 1. On clear_fault: retry_cnt <= 0, timeout_ch <= 0, go to BOOT.
- retry_cnt clears to 0 in RUN on the first cycle where every enabled channel has seen >= 1 edge since RUN entry (healthy).
- sys_reset = registered FSM reset level OR ext_reset.
  - The ext_reset path is combinational, zero latency.
  - ext_reset does not change FSM state except holding counters at 0.
- timeout_ch is sticky until the next trip or clear_fault; it is not cleared by a healthy run.
- ch_en deasserted mid-count clears that channel immediately. A channel enabled in RUN starts counting from 0.
- clear_fault outside FAULT is ignored.
- Trip in the same cycle as ext_reset: ext_reset wins (counters held at 0, no trip).

Test Plan:
(Bench parameters: N_CH=2, TIMEOUT=16, BOOT_HOLD=8, RESET_HOLD=4, MAX_RETRY=2, ARM_ON_FIRST=1, EDGE_POL=1.)
1. Boot/arm: release rst_n, both ch_en=1 -> sys_reset=1 for 8 cycles, then 0. Block stays in ARM until both channels pulse, then counting starts.
2. Healthy: heartbeat on both channels every 10 cycles for 200 cycles -> sys_reset never asserts, retry_cnt=0.
3. Single trip: stop ch1 only -> 16 cycles after ch1's last edge is registered, sys_reset=1 for exactly 4 cycles, timeout_ch=2'b10, retry_cnt=1. Resuming both heartbeats clears retry_cnt to 0 but timeout_ch stays 2'b10.
4. Fault: keep ch0 dead -> second trip gives fault=1 with sys_reset held high for 1000 cycles. A clear_fault pulse gives retry_cnt=0, timeout_ch=0, then an 8-cycle BOOT hold.
5. Races:
   - Edge on the exact cycle the counter reaches 16 -> no trip.
   - ext_reset high for 3 cycles mid-RUN -> sys_reset high in the same cycles and counters restart from 0.
   - ch_en[1]=0 with ch1 dead -> no trip.
6. Async reset mid-HOLD: drop rst_n -> sys_reset=1, fault=0, retry_cnt=0 immediately, without waiting for clk.
